// File: rtl/scale_pkg.sv
// Shared definitions for the scaled-row DDR writer: write FSM encoding and default burst geometry.
package scale_pkg;

    localparam int BURST_LEN_DEF   = 64;
    localparam int LINE_STRIDE_DEF = 2048;
    localparam int LINE_DEPTH      = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_NEXT = 2'd3
    } wr_state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port (1-cycle latency).
module line_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/scale_row_writer.sv
// Buffers scaled rows in two ping-pong line banks and drains each pending row to memory as bursts.
module scale_row_writer
    import scale_pkg::*;
#(
    parameter int PIX_WIDTH   = 16,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int ADDR_W      = 24,
    parameter int LINE_STRIDE = LINE_STRIDE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          dst_row,
    input  logic [10:0]          x_pos,
    input  logic [PIX_WIDTH-1:0] in_data,
    input  logic                 data_vaild,
    input  logic [12:0]          row_len,
    input  logic [12:0]          frame_rows,
    input  logic [ADDR_W-1:0]    frame_base,
    output logic                 line_ready,
    output logic                 wr_burst_req,
    output logic [9:0]           wr_burst_len,
    output logic [ADDR_W-1:0]    wr_burst_addr,
    input  logic                 wr_burst_data_req,
    output logic [PIX_WIDTH-1:0] wr_burst_data,
    input  logic                 wr_burst_finish,
    output logic                 frame_done,
    output logic                 overflow
);

    wr_state_t state, state_nxt;

    logic                      vaild_q;
    logic [1:0]                pending;
    logic                      fill_bank;
    logic                      drain_bank;
    logic [1:0][10:0]          row_index;
    logic [12:0]               offset;
    logic [10:0]               rd_ptr;
    logic [1:0][PIX_WIDTH-1:0] rdata;

    logic        in_range, wr_en, rd_en, row_end, bank_free, accept;
    logic [12:0] remain, next_off;
    logic [9:0]  len;
    logic [1:0]  pending_eff;

    assign in_range  = (x_pos != 11'd0) && ({2'b00, x_pos} <= row_len);
    // A pending bank still being drained must not be overwritten by a row that will be dropped.
    assign wr_en     = data_vaild && in_range && !pending[fill_bank];
    assign rd_en     = wr_burst_data_req && (state == ST_REQ || state == ST_DATA);
    assign row_end   = vaild_q && !data_vaild;

    assign remain    = row_len - offset;
    assign len       = (remain > 13'(BURST_LEN)) ? 10'(BURST_LEN) : remain[9:0];
    assign next_off  = offset + 13'(len);
    assign bank_free = (state == ST_NEXT) && (next_off >= row_len);

    // A bank released this cycle is already free for a row ending in the same cycle.
    assign pending_eff = pending & ~(bank_free ? (2'b01 << drain_bank) : 2'b00);
    assign accept      = row_end && !pending_eff[fill_bank];

    assign line_ready    = ~&pending;
    assign wr_burst_len  = (state == ST_IDLE) ? 10'd0 : len;
    assign wr_burst_addr = (state == ST_IDLE) ? '0 :
                           frame_base + ADDR_W'(row_index[drain_bank]) * ADDR_W'(LINE_STRIDE)
                           + ADDR_W'(offset);
    assign wr_burst_data = rdata[drain_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_ram #(
            .WIDTH (PIX_WIDTH),
            .DEPTH (LINE_DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && (fill_bank == 1'(b))),
            .waddr (x_pos - 11'd1),
            .wdata (in_data),
            .re    (rd_en && (drain_bank == 1'(b))),
            .raddr (rd_ptr),
            .rdata (rdata[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        wr_burst_req = 1'b0;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: if (pending[drain_bank]) state_nxt = ST_REQ;
            ST_REQ: begin
                wr_burst_req = 1'b1;
                if (wr_burst_data_req) state_nxt = ST_DATA;
            end
            ST_DATA: if (wr_burst_finish) state_nxt = ST_NEXT;
            ST_NEXT: begin
                state_nxt  = bank_free ? ST_IDLE : ST_REQ;
                frame_done = bank_free && ({2'b00, row_index[drain_bank]} == frame_rows - 13'd1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Banks fill and drain in the same alternating order, so drain_bank always names the oldest row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vaild_q    <= 1'b0;
            pending    <= 2'b00;
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            row_index  <= '0;
            offset     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            vaild_q <= data_vaild;
            pending <= pending_eff | (accept ? (2'b01 << fill_bank) : 2'b00);
            if (accept) begin
                row_index[fill_bank] <= dst_row - 11'd1;
                fill_bank            <= ~fill_bank;
            end
            if (row_end && !accept) overflow <= 1'b1;
            if (bank_free) drain_bank <= ~drain_bank;
            if (state == ST_NEXT) begin
                offset <= bank_free ? 13'd0 : next_off;
                rd_ptr <= bank_free ? 11'd0 : next_off[10:0];
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_scale_row_writer.sv
// Bench for scale_row_writer: directed and random rows checked against a two-bank line model.
module tb_scale_row_writer;

    localparam int PW     = 16;
    localparam int AW     = 24;
    localparam int BL     = 64;
    localparam int STRIDE = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   dst_row, x_pos;
    logic [PW-1:0] in_data;
    logic          data_vaild;
    logic [12:0]   row_len, frame_rows;
    logic [AW-1:0] frame_base;
    logic          line_ready, wr_burst_req;
    logic [9:0]    wr_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic          wr_burst_data_req, wr_burst_finish;
    logic [PW-1:0] wr_burst_data;
    logic          frame_done, overflow;

    int n_checks = 0;
    int n_err    = 0;
    int fd_count = 0;

    // Reference model: bank images, fill pointer, pending count, expected bursts and pixels.
    logic [PW-1:0] bank_img [2][2048];
    int            fill = 0;
    int            pend = 0;
    int            exp_fd = 0;
    logic [AW-1:0] q_addr [$];
    int            q_len  [$];
    bit            q_last [$];
    bit            q_fd   [$];
    logic [PW-1:0] q_pix  [$];
    logic [AW-1:0] last_addr;
    int            last_len;

    scale_row_writer dut (
        .clk               (clk),
        .rst               (rst),
        .dst_row           (dst_row),
        .x_pos             (x_pos),
        .in_data           (in_data),
        .data_vaild        (data_vaild),
        .row_len           (row_len),
        .frame_rows        (frame_rows),
        .frame_base        (frame_base),
        .line_ready        (line_ready),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_finish   (wr_burst_finish),
        .frame_done        (frame_done),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        fill = 0;
        pend = 0;
        q_addr.delete();
        q_len.delete();
        q_last.delete();
        q_fd.delete();
        q_pix.delete();
    endtask

    task automatic put_pix(input int x, input int v);
        x_pos      = 11'(x);
        in_data    = PW'(v);
        data_vaild = 1'b1;
        if (x >= 1 && x <= int'(row_len) && pend < 2) bank_img[fill][x-1] = PW'(v);
        tick();
    endtask

    task automatic end_row();
        int            rl;
        int            idx;
        logic [AW-1:0] a;
        data_vaild = 1'b0;
        if (pend < 2) begin
            rl  = int'(row_len);
            idx = int'(dst_row) - 1;
            for (int off = 0; off < rl; off += BL) begin
                int n;
                n = (rl - off < BL) ? rl - off : BL;
                a = frame_base + AW'(idx * STRIDE + off);
                q_addr.push_back(a);
                q_len.push_back(n);
                q_last.push_back(off + n == rl);
                q_fd.push_back((off + n == rl) && (idx == int'(frame_rows) - 1));
            end
            for (int i = 0; i < rl; i++) q_pix.push_back(bank_img[fill][i]);
            pend++;
            fill ^= 1;
        end
        tick();
        tick();
    endtask

    task automatic send_row(input int dst, input bit junk);
        int rl;
        rl      = int'(row_len);
        dst_row = 11'(dst);
        for (int x = 1; x <= rl; x++) begin
            if (junk && $urandom_range(0, 7) == 0)
                put_pix(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2047, rl + 1)),
                        int'($urandom_range(65535, 0)));
            put_pix(x, int'($urandom_range(65535, 0)));
        end
        end_row();
    endtask

    task automatic serve_burst();
        int            cnt;
        int            bad;
        int            el;
        logic [AW-1:0] ea;
        bit            elast, efd;
        logic [PW-1:0] ep;
        cnt = 0;
        bad = 0;
        if (q_addr.size() == 0) begin
            check("burst_expected", 32'd0, 32'd1);
            return;
        end
        ea    = q_addr.pop_front();
        el    = q_len.pop_front();
        elast = q_last.pop_front();
        efd   = q_fd.pop_front();
        while (wr_burst_req !== 1'b1 && cnt < 500) begin
            tick();
            cnt++;
        end
        if (wr_burst_req !== 1'b1) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        last_addr = wr_burst_addr;
        last_len  = int'(wr_burst_len);
        check("burst_addr", 32'(wr_burst_addr), 32'(ea));
        check("burst_len", 32'(wr_burst_len), 32'(el));
        for (int i = 0; i < el; i++) begin
            wr_burst_data_req = 1'b1;
            tick();
            ep = q_pix.pop_front();
            if (wr_burst_data !== ep) bad++;
        end
        wr_burst_data_req = 1'b0;
        check("burst_data_mismatches", 32'(bad), 32'd0);
        wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        tick();
        if (elast) begin
            pend--;
            if (efd) exp_fd++;
            check("frame_done_count", 32'(fd_count), 32'(exp_fd));
        end
    endtask

    task automatic serve_all();
        while (q_addr.size() > 0) serve_burst();
    endtask

    initial begin
        int fd_base;
        int cnt;
        int dsts [2];
        int nrows;

        rst               = 1'b1;
        dst_row           = '0;
        x_pos             = '0;
        in_data           = '0;
        data_vaild        = 1'b0;
        row_len           = 13'd100;
        frame_rows        = 13'd1000;
        frame_base        = '0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(wr_burst_req), 32'd0);
        check("rst_len", 32'(wr_burst_len), 32'd0);
        check("rst_addr", 32'(wr_burst_addr), 32'd0);
        check("rst_data", 32'(wr_burst_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_line_ready", 32'(line_ready), 32'd1);
        rst = 1'b0;
        tick();

        // 100-pixel ramp on row 1 splits into a full and a 36-pixel burst.
        dst_row = 11'd1;
        for (int x = 1; x <= 100; x++) put_pix(x, x);
        end_row();
        check("ramp_line_ready", 32'(line_ready), 32'd1);
        serve_burst();
        check("ramp_b1_addr", 32'(last_addr), 32'd0);
        check("ramp_b1_len", 32'(last_len), 32'd64);
        serve_burst();
        check("ramp_b2_addr", 32'(last_addr), 32'd64);
        check("ramp_b2_len", 32'(last_len), 32'd36);

        // Row 3 lands two strides above the frame base.
        row_len    = 13'd64;
        frame_base = 24'h001000;
        send_row(3, 1'b0);
        serve_burst();
        check("row3_addr", 32'(last_addr), 32'h2000);
        check("row3_len", 32'(last_len), 32'd64);

        // Out-of-range columns are dropped; unwritten columns keep older bank contents.
        row_len    = 13'd40;
        frame_base = '0;
        dst_row    = 11'd5;
        put_pix(0, 16'hDEAD);
        for (int x = 1; x <= 39; x++) put_pix(x, int'($urandom_range(65535, 0)));
        put_pix(41, 16'hBEEF);
        end_row();
        serve_all();
        row_len = 13'd41;
        send_row(6, 1'b0);
        serve_all();
        dst_row = 11'd7;
        for (int x = 1; x <= 40; x++) put_pix(x, int'($urandom_range(65535, 0)));
        end_row();
        serve_all();

        // Three rows with the write side stalled: the third is dropped and overflow sticks.
        row_len    = 13'd20;
        frame_base = 24'h004000;
        send_row(10, 1'b0);
        check("ovf_ready_1", 32'(line_ready), 32'd1);
        send_row(11, 1'b0);
        check("ovf_ready_2", 32'(line_ready), 32'd0);
        check("ovf_clear_2", 32'(overflow), 32'd0);
        send_row(12, 1'b0);
        check("ovf_set_3", 32'(overflow), 32'd1);
        check("ovf_ready_3", 32'(line_ready), 32'd0);
        serve_all();
        check("ovf_ready_drained", 32'(line_ready), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_reset();
        check("ovf_reset", 32'(overflow), 32'd0);
        check("ovf_reset_ready", 32'(line_ready), 32'd1);

        // Two-row frame: frame_done fires once, after the last burst of row 2.
        fd_base    = fd_count;
        row_len    = 13'd30;
        frame_rows = 13'd2;
        frame_base = AW'($urandom);
        send_row(1, 1'b1);
        serve_all();
        check("frame_done_row1", 32'(fd_count - fd_base), 32'd0);
        send_row(2, 1'b1);
        serve_all();
        check("frame_done_row2", 32'(fd_count - fd_base), 32'd1);

        // Random rows, including single-pixel, burst-boundary and address-wrap cases.
        for (int it = 0; it < 8; it++) begin
            case (it)
                0:       row_len = 13'd1;
                1:       row_len = 13'd65;
                2:       row_len = 13'd128;
                default: row_len = 13'($urandom_range(200, 1));
            endcase
            frame_base = (it == 2) ? 24'hFFFF00 : AW'($urandom);
            nrows      = int'($urandom_range(2, 1));
            dsts[0]    = int'($urandom_range(2047, 1));
            dsts[1]    = int'($urandom_range(2047, 1));
            frame_rows = ($urandom_range(1, 0) == 1) ? 13'(dsts[nrows-1])
                                                    : 13'($urandom_range(4095, 1));
            for (int r = 0; r < nrows; r++) begin
                send_row(dsts[r], 1'b1);
                check("rnd_line_ready", 32'(line_ready), (pend < 2) ? 32'd1 : 32'd0);
            end
            serve_all();
        end

        // Reset in the middle of a data phase abandons the burst and the row.
        row_len    = 13'd50;
        frame_rows = 13'd1;
        frame_base = '0;
        send_row(1, 1'b0);
        cnt = 0;
        while (wr_burst_req !== 1'b1 && cnt < 500) begin
            tick();
            cnt++;
        end
        check("rst_mid_req_seen", 32'(wr_burst_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            wr_burst_data_req = 1'b1;
            tick();
        end
        fd_base           = fd_count;
        rst               = 1'b1;
        wr_burst_data_req = 1'b0;
        tick();
        check("rst_mid_req", 32'(wr_burst_req), 32'd0);
        check("rst_mid_ready", 32'(line_ready), 32'd1);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) tick();
        check("rst_mid_no_restart", 32'(wr_burst_req), 32'd0);
        check("rst_mid_no_frame_done", 32'(fd_count - fd_base), 32'd0);

        row_len    = 13'd70;
        frame_rows = 13'd1000;
        send_row(2, 1'b1);
        serve_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/scale_row_writer.md
SCALE_ROW_WRITER -- requirements
Module: scale_row_writer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 16, pixel width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 64, maximum pixels per write burst.
REQ-003 SHALL have parameter ADDR_W, default 24, pixel-unit address width.
REQ-004 SHALL have parameter LINE_STRIDE, default 2048, pixel offset between consecutive destination rows.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port dst_row, input, 11, 1-based row number of the streaming row.
REQ-009 SHALL have port x_pos, input, 11, 1-based column of in_data.
REQ-010 SHALL have port in_data, input, PIX_WIDTH, scaled pixel.
REQ-011 SHALL have port data_vaild, input, 1, in_data/x_pos qualifier.
REQ-012 SHALL have port row_len, input, 13, pixels per row to store, 1..2047.
REQ-013 SHALL have port frame_rows, input, 13, rows per frame.
REQ-014 SHALL have port frame_base, input, ADDR_W, frame start address.
REQ-015 SHALL have port line_ready, output, 1, at least one line bank free.
REQ-016 SHALL have ports wr_burst_req (out 1), wr_burst_len (out 10), wr_burst_addr (out ADDR_W), wr_burst_data_req (in 1), wr_burst_data (out PIX_WIDTH), wr_burst_finish (in 1).
REQ-017 SHALL have ports frame_done (out 1, one-cycle pulse) and overflow (out 1, sticky).

Function
REQ-018 SHALL hold two line banks (ping-pong), each 2048 x PIX_WIDTH; the fill bank receives in_data at address x_pos-1 when data_vaild=1, 1<=x_pos<=row_len; other x_pos values SHALL be dropped.
REQ-019 SHALL detect row end on data_vaild falling (1 then 0); at that cycle it SHALL latch row_index=dst_row-1 for the fill bank, mark it pending, and swap fill bank.
REQ-020 If row end occurs while both banks are pending, the row SHALL be discarded, no swap, and overflow SHALL set until reset.
REQ-021 line_ready SHALL be 1 when fewer than two banks are pending.
REQ-022 Write FSM states: IDLE, REQ, DATA, NEXT; IDLE->REQ when any bank pending (oldest first).
REQ-023 In REQ, wr_burst_req=1 with wr_burst_addr=frame_base+row_index*LINE_STRIDE+offset and wr_burst_len=min(BURST_LEN, row_len-offset); REQ->DATA on first wr_burst_data_req.
REQ-024 In REQ/DATA, each wr_burst_data_req cycle SHALL read the next bank word; wr_burst_data SHALL be valid the following cycle (1-cycle latency).
REQ-025 On wr_burst_finish in DATA: ->NEXT; NEXT adds wr_burst_len to offset; if offset<row_len ->REQ, else bank freed, offset=0, ->IDLE.
REQ-026 frame_done SHALL pulse one cycle in NEXT when the freed row has row_index=frame_rows-1.
REQ-027 Address arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-028 A bank freed and a row end in the same cycle SHALL both take effect; no overflow.
REQ-029 Unwritten bank positions SHALL output stale contents; no clearing.

Reset
REQ-030 On rst: FSM=IDLE, both banks free, fill bank=0, offset=0, wr_burst_req=0, wr_burst_len=0, wr_burst_addr=0, wr_burst_data=0, frame_done=0, overflow=0, line_ready=1; bank RAM contents undefined.
REQ-031 Reset mid-burst SHALL abandon the burst and the pending rows.

Structure
REQ-032 FSM state encodings and BURST_LEN/LINE_STRIDE defaults SHALL live in shared package scale_pkg.
REQ-033 Bank storage SHALL be one sub-module, line_ram (simple dual-port, 1-cycle read), instantiated twice.

Verification
REQ-034 row_len=100, x_pos 1..100 ramp, dst_row=1, frame_base=0 -> two bursts: addr 0 len 64, addr 64 len 36; data matches ramp.
REQ-035 dst_row=3, row_len=64, frame_base=0x1000 -> one burst addr 0x1000+2*2048=0x2000, len 64.
REQ-036 Three rows ended with wr_burst_data_req held 0 -> line_ready=0 after second, third row dropped, overflow=1.
REQ-037 frame_rows=2, rows 1,2 written -> frame_done pulses once, after row 2 final finish.
REQ-038 x_pos=0 and x_pos=row_len+1 presented -> not stored; burst data unaffected.
REQ-039 rst asserted during DATA -> wr_burst_req=0, line_ready=1 next cycle, no frame_done.
